// File: rtl/ddr3_cpu_req_queue.sv
// ddr3_cpu_req_queue: buffers CPU read/write requests in a small FIFO and
// issues them one at a time to the DDR3 controller CPU port. Only one
// controller transaction is in flight at a time, so read data comes back
// in issue order.
// Optional build macro DDR3_REQ_QUEUE_STATS_EN adds saturating 16-bit
// counters o_wr_issued, o_rd_issued and o_stall_cycles.
module ddr3_cpu_req_queue #(
    parameter int unsigned ADDR_W = 27,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              i_cpu_ck,
    input  logic              i_cpu_reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_cmd,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mc_enable,
    output logic              mc_valid,
    output logic              mc_cmd,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [DATA_W-1:0] mc_wr_data,
    input  logic              mc_data_rdy,
    input  logic [DATA_W-1:0] mc_rd_data,
    input  logic              mc_rd_data_valid
`ifdef DDR3_REQ_QUEUE_STATS_EN
    ,
    output logic [15:0]       o_wr_issued,
    output logic [15:0]       o_rd_issued,
    output logic [15:0]       o_stall_cycles
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = 1 + ADDR_W + DATA_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_HOLD,
        S_WAIT_RD
    } state_t;

    state_t              state_q, state_d;
    logic [ENT_W-1:0]    fifo_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                req_ready_q, req_ready_d;
    logic                mc_enable_q;
    logic                mc_valid_q, mc_valid_d;
    logic                mc_cmd_q, mc_cmd_d;
    logic [ADDR_W-1:0]   mc_addr_q, mc_addr_d;
    logic [DATA_W-1:0]   mc_wr_data_q, mc_wr_data_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                push, pop, empty;
    logic                head_cmd;
    logic [ADDR_W-1:0]   head_addr;
    logic [DATA_W-1:0]   head_wdata;

    assign push  = req_valid && req_ready_q;
    assign empty = (count_q == '0);
    assign {head_cmd, head_addr, head_wdata} = fifo_q[rd_ptr_q];

    // Request storage; contents need no reset since occupancy gates use.
    always_ff @(posedge i_cpu_ck) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {req_cmd, req_addr, req_wdata};
        end
    end

    // Occupancy next-state; ready is the registered complement of full.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        req_ready_d = (count_d != FULL_CNT);
    end

    // Issue FSM: controller outputs are loaded on the IDLE->ISSUE decision
    // so that they are registered yet valid exactly during ISSUE.
    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        mc_valid_d   = 1'b0;
        mc_cmd_d     = mc_cmd_q;
        mc_addr_d    = mc_addr_q;
        mc_wr_data_d = mc_wr_data_q;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (!empty && mc_data_rdy) begin
                    state_d      = S_ISSUE;
                    mc_valid_d   = 1'b1;
                    mc_cmd_d     = head_cmd;
                    mc_addr_d    = head_addr;
                    mc_wr_data_d = head_wdata;
                end
            end
            S_ISSUE: begin
                pop     = 1'b1;
                state_d = mc_cmd_q ? S_HOLD : S_WAIT_RD;
            end
            S_HOLD: begin
                state_d = S_IDLE;
            end
            S_WAIT_RD: begin
                if (mc_rd_data_valid) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = mc_rd_data;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, pointers and all registered outputs.
    always_ff @(posedge i_cpu_ck) begin
        if (i_cpu_reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            req_ready_q  <= 1'b0;
            mc_enable_q  <= 1'b0;
            mc_valid_q   <= 1'b0;
            mc_cmd_q     <= 1'b0;
            mc_addr_q    <= '0;
            mc_wr_data_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q      <= count_d;
            req_ready_q  <= req_ready_d;
            mc_enable_q  <= 1'b1;
            mc_valid_q   <= mc_valid_d;
            mc_cmd_q     <= mc_cmd_d;
            mc_addr_q    <= mc_addr_d;
            mc_wr_data_q <= mc_wr_data_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign mc_enable  = mc_enable_q;
    assign mc_valid   = mc_valid_q;
    assign mc_cmd     = mc_cmd_q;
    assign mc_addr    = mc_addr_q;
    assign mc_wr_data = mc_wr_data_q;

`ifdef DDR3_REQ_QUEUE_STATS_EN
    logic [15:0] wr_issued_q, rd_issued_q, stall_q;

    // Saturating activity counters.
    always_ff @(posedge i_cpu_ck) begin
        if (i_cpu_reset) begin
            wr_issued_q <= '0;
            rd_issued_q <= '0;
            stall_q     <= '0;
        end else begin
            if (state_q == S_ISSUE && mc_cmd_q && wr_issued_q != '1)
                wr_issued_q <= wr_issued_q + 16'd1;
            if (state_q == S_ISSUE && !mc_cmd_q && rd_issued_q != '1)
                rd_issued_q <= rd_issued_q + 16'd1;
            if (state_q == S_IDLE && !empty && !mc_data_rdy && stall_q != '1)
                stall_q <= stall_q + 16'd1;
        end
    end

    assign o_wr_issued    = wr_issued_q;
    assign o_rd_issued    = rd_issued_q;
    assign o_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_ddr3_cpu_req_queue.sv
// Self-checking bench for ddr3_cpu_req_queue: directed stimulus pushes
// expected controller issues and read responses into queues; a monitor
// pops and compares whenever the DUT presents mc_valid or rsp_valid.
`timescale 1ns/1ps
module tb_ddr3_cpu_req_queue;

    localparam int unsigned ADDR_W = 27;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              i_cpu_reset;
    logic              req_valid, req_ready, req_cmd;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              mc_enable, mc_valid, mc_cmd;
    logic [ADDR_W-1:0] mc_addr;
    logic [DATA_W-1:0] mc_wr_data;
    logic              mc_data_rdy;
    logic [DATA_W-1:0] mc_rd_data;
    logic              mc_rd_data_valid;
`ifdef DDR3_REQ_QUEUE_STATS_EN
    logic [15:0]       wr_issued, rd_issued, stall_cycles;
`endif

    always #5 clk = ~clk;

    ddr3_cpu_req_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .i_cpu_ck         (clk),
        .i_cpu_reset      (i_cpu_reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_cmd          (req_cmd),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_rdata        (rsp_rdata),
        .mc_enable        (mc_enable),
        .mc_valid         (mc_valid),
        .mc_cmd           (mc_cmd),
        .mc_addr          (mc_addr),
        .mc_wr_data       (mc_wr_data),
        .mc_data_rdy      (mc_data_rdy),
        .mc_rd_data       (mc_rd_data),
        .mc_rd_data_valid (mc_rd_data_valid)
`ifdef DDR3_REQ_QUEUE_STATS_EN
        ,
        .o_wr_issued      (wr_issued),
        .o_rd_issued      (rd_issued),
        .o_stall_cycles   (stall_cycles)
`endif
    );

    typedef struct {
        logic              cmd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                exp_cyc;
    } iss_t;

    iss_t        exp_iss[$];
    logic [63:0] exp_rsp[$];
    int          issue_cyc[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          issue_cnt = 0;
    int          rsp_cnt = 0;
    int          last_push_cyc = 0;
    int          last_rdv_cyc = -100;

    // controller model controls
    int          rd_delay = 3;
    bit          echo_mode = 1'b1;
    logic [63:0] fixed_rdata = '0;
    int          stray_req = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every controller issue and every read response.
    initial begin : monitor
        bit rd_outstanding;
        int last_issue;
        iss_t e;
        logic [63:0] r;
        rd_outstanding = 1'b0;
        last_issue = -100;
        forever begin
            @(negedge clk);
            if (i_cpu_reset) begin
                rd_outstanding = 1'b0;
            end else begin
                if (mc_valid) begin
                    issue_cnt++;
                    issue_cyc.push_back(cyc);
                    chk("one_outstanding", 64'(rd_outstanding), 64'd0);
                    checks++;
                    if (cyc - last_issue < 3) begin
                        errors++;
                        $display("FAIL issue_gap: got %0d cycles expected >= 3", cyc - last_issue);
                    end
                    if (exp_iss.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_issue: got cmd=%0b addr=%h expected no issue", mc_cmd, mc_addr);
                    end else begin
                        e = exp_iss.pop_front();
                        chk("issue_cmd", 64'(mc_cmd), 64'(e.cmd));
                        chk("issue_addr", 64'(mc_addr), 64'(e.addr));
                        if (e.cmd) chk("issue_wdata", mc_wr_data, e.data);
                        if (e.exp_cyc >= 0) chk("issue_latency", 64'(cyc), 64'(e.exp_cyc));
                    end
                    if (!mc_cmd) rd_outstanding = 1'b1;
                    last_issue = cyc;
                end
                if (rsp_valid) begin
                    rsp_cnt++;
                    rd_outstanding = 1'b0;
                    chk("rsp_timing", 64'(cyc), 64'(last_rdv_cyc + 1));
                    if (exp_rsp.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: got %h expected no response", rsp_rdata);
                    end else begin
                        r = exp_rsp.pop_front();
                        chk("rsp_data", rsp_rdata, r);
                    end
                end
            end
        end
    end

    // Controller model: stores writes, answers reads after rd_delay cycles.
    initial begin : ctrl_model
        logic [63:0]       mem [logic [ADDR_W-1:0]];
        logic [ADDR_W-1:0] rd_addr;
        int                rd_cnt;
        int                stray_ack;
        rd_cnt = 0;
        stray_ack = 0;
        rd_addr = '0;
        mc_rd_data_valid = 1'b0;
        mc_rd_data = '0;
        forever begin
            @(negedge clk);
            mc_rd_data_valid = 1'b0;
            if (i_cpu_reset) begin
                rd_cnt = 0;
            end else begin
                if (rd_cnt > 0) begin
                    rd_cnt--;
                    if (rd_cnt == 0) begin
                        mc_rd_data_valid = 1'b1;
                        mc_rd_data = (echo_mode && mem.exists(rd_addr)) ? mem[rd_addr] : fixed_rdata;
                        last_rdv_cyc = cyc;
                    end
                end
                if (mc_valid) begin
                    if (mc_cmd) mem[mc_addr] = mc_wr_data;
                    else begin
                        rd_cnt = rd_delay;
                        rd_addr = mc_addr;
                    end
                end
                if (stray_req != stray_ack) begin
                    stray_ack = stray_req;
                    mc_rd_data_valid = 1'b1;
                    mc_rd_data = 64'hBAD0_BAD0_BAD0_BAD0;
                    last_rdv_cyc = cyc;
                end
            end
        end
    end

    // Offer one request (called at a negedge); waits for acceptance.
    task automatic push(input logic cmd, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data, input bit expect_issue,
                        input bit exact);
        int  waited = 0;
        bit  done = 1'b0;
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_addr  = addr;
        req_wdata = data;
        while (!done) begin
            if (req_ready === 1'b1) begin
                done = 1'b1;
                last_push_cyc = cyc;
                if (expect_issue) exp_iss.push_back('{cmd, addr, data, exact ? cyc + 2 : -1});
            end
            @(negedge clk);
            if (!done) begin
                waited++;
                if (waited > 60) begin
                    checks++;
                    errors++;
                    $display("FAIL push_accept: got no req_ready in %0d cycles expected acceptance", waited);
                    done = 1'b1;
                end
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_iss.size() != 0 || exp_rsp.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s_drain: got %0d issues %0d responses pending expected 0",
                     name, exp_iss.size(), exp_rsp.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name, {56'd0, req_ready, rsp_valid, |rsp_rdata, mc_enable, mc_valid,
                   mc_cmd, |mc_addr, |mc_wr_data}, 64'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stimulus
        int rc, ic, n;
        i_cpu_reset = 1'b1;
        req_valid   = 1'b0;
        req_cmd     = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        mc_data_rdy = 1'b1;

        // reset held for three cycles, then released at a negedge
        repeat (3) begin
            @(negedge clk);
            chk_reset_outputs("reset_outputs");
        end
        i_cpu_reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 64'(req_ready), 64'd1);
        chk("enable_after_reset", 64'(mc_enable), 64'd1);
        chk("valid_after_reset", 64'(mc_valid), 64'd0);

        // stray read-data-valid while idle is ignored
        rc = rsp_cnt;
        stray_req++;
        repeat (5) @(negedge clk);
        chk("stray_idle_no_rsp", 64'(rsp_cnt), 64'(rc));

        // single write, exact 2-cycle push-to-issue latency
        push(1'b1, 27'h0000100, 64'hDEADBEEF_CAFEF00D, 1'b1, 1'b1);
        drain("single_write");

        // single read answered 10 cycles after issue
        echo_mode   = 1'b0;
        fixed_rdata = 64'h0123456789ABCDEF;
        rd_delay    = 10;
        exp_rsp.push_back(64'h0123456789ABCDEF);
        push(1'b0, 27'h0000100, 64'd0, 1'b1, 1'b1);
        drain("single_read");
        chk("rsp_rdata_held", rsp_rdata, 64'h0123456789ABCDEF);

        // fill with controller stalled, fifth request held off
        mc_data_rdy = 1'b0;
        for (int i = 0; i < 4; i++)
            push(1'b1, 27'h10 + 27'(i), 64'h1000_0000_0000_0000 + 64'(i), 1'b1, 1'b0);
        chk("full_ready_low", 64'(req_ready), 64'd0);
        req_valid = 1'b1;
        req_cmd   = 1'b1;
        req_addr  = 27'h14;
        req_wdata = 64'h1000_0000_0000_0004;
        ic = issue_cnt;
        repeat (3) begin
            @(negedge clk);
            chk("full_hold_off", 64'(req_ready), 64'd0);
        end
        chk("no_issue_when_stalled", 64'(issue_cnt), 64'(ic));
        n = issue_cyc.size();
        mc_data_rdy = 1'b1;
        push(1'b1, 27'h14, 64'h1000_0000_0000_0004, 1'b1, 1'b0);
        if (issue_cyc.size() > n)
            chk("ready_rises_after_pop", 64'(last_push_cyc), 64'(issue_cyc[n] + 1));
        else
            chk("ready_rises_after_pop", 64'(issue_cyc.size()), 64'(n + 1));
        drain("fill");

        // mixed ordering against an echoing controller
        echo_mode = 1'b1;
        rd_delay  = 3;
        push(1'b1, 27'h0000200, 64'h1111_2222_3333_4444, 1'b1, 1'b0);
        exp_rsp.push_back(64'h1111_2222_3333_4444);
        push(1'b0, 27'h0000200, 64'd0, 1'b1, 1'b0);
        push(1'b1, 27'h0000300, 64'h5555_6666_7777_8888, 1'b1, 1'b0);
        exp_rsp.push_back(64'h5555_6666_7777_8888);
        push(1'b0, 27'h0000300, 64'd0, 1'b1, 1'b0);
        drain("mixed");

        // reset while a read is outstanding and two writes are queued
        echo_mode   = 1'b0;
        fixed_rdata = 64'hAAAA_AAAA_AAAA_AAAA;
        rd_delay    = 20;
        push(1'b0, 27'h0000400, 64'd0, 1'b1, 1'b0);
        push(1'b1, 27'h0000401, 64'h1, 1'b0, 1'b0);
        push(1'b1, 27'h0000402, 64'h2, 1'b0, 1'b0);
        drain("pre_reset_read");
        rc = rsp_cnt;
        ic = issue_cnt;
        i_cpu_reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_outputs("midop_reset_outputs");
        i_cpu_reset = 1'b0;
        @(negedge clk);
        stray_req++;
        repeat (10) @(negedge clk);
        chk("reset_discards_rsp", 64'(rsp_cnt), 64'(rc));
        chk("reset_empties_fifo", 64'(issue_cnt), 64'(ic));
        chk("ready_after_midop_reset", 64'(req_ready), 64'd1);

        chk("exp_iss_empty", 64'(exp_iss.size()), 64'd0);
        chk("exp_rsp_empty", 64'(exp_rsp.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr3_cpu_req_queue.md
# ddr3_cpu_req_queue

Request queue between the CPU/testbench traffic source and the DDR3 memory controller's CPU port. It accepts read and write requests back-to-back into a FIFO. It then issues them one at a time to the controller, obeying the controller's ready/valid protocol, and returns read data to the requester in issue order.

## Interface

Parameters:
- ADDR_W, 27: CPU address width; must equal the controller's ADDR_MCTRL.
- DATA_W, 64: burst data width (8*DQ_BITS).
- DEPTH, 4: request FIFO entries; power of two, ≥2.

Ports:
- i_cpu_ck, in, 1: single clock for the whole block.
- i_cpu_reset, in, 1: synchronous, active-high reset.
- req_valid, in, 1: request offered.
- req_ready, out, 1: FIFO can accept; registered, equals !full.
- req_cmd, in, 1: 1 = write, 0 = read.
- req_addr, in, ADDR_W: request address.
- req_wdata, in, DATA_W: write data; ignored for reads.
- rsp_valid, out, 1: one-cycle pulse when read data is returned.
- rsp_rdata, out, DATA_W: read data; held until the next rsp_valid.
- mc_enable, out, 1: drives the controller's i_cpu_enable.
- mc_valid, out, 1: drives i_cpu_valid.
- mc_cmd, out, 1: drives i_cpu_cmd.
- mc_addr, out, ADDR_W: drives i_cpu_addr.
- mc_wr_data, out, DATA_W: drives i_cpu_wr_data.
- mc_data_rdy, in, 1: from o_cpu_data_rdy.
- mc_rd_data, in, DATA_W: from o_cpu_rd_data.
- mc_rd_data_valid, in, 1: from o_cpu_rd_data_valid.

## Operation

- FIFO entry format: {cmd, addr, wdata}.
  - Push when req_valid && req_ready.
  - Pop on issue.
  - Occupancy counter is clog2(DEPTH)+1 bits; read/write pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, HOLD, WAIT_RD.
  - IDLE: when FIFO is non-empty and mc_data_rdy=1, go to ISSUE.
  - ISSUE: one cycle. mc_valid=1; mc_cmd/addr/wr_data = FIFO head; pop the head. If cmd=1, go to HOLD; otherwise go to WAIT_RD.
  - HOLD: one cycle; mc_data_rdy is ignored. Then go to IDLE. This masks the controller's ready-deassert latency.
  - WAIT_RD: wait for mc_rd_data_valid=1. Capture mc_rd_data into rsp_rdata, pulse rsp_valid next cycle, then go to IDLE.
- mc_valid is high only in ISSUE. mc_addr, mc_cmd and mc_wr_data hold their last issued values otherwise.
- Only one controller transaction is outstanding at any time. Read responses are therefore in order, and no tag is needed.
- Boundary conditions:
  - Full FIFO with a same-cycle pop: req_ready is still 0 in that cycle, so no push happens. req_ready rises the following cycle.
  - Push into an empty FIFO while in IDLE: the entry is eligible for issue the next cycle.
  - mc_rd_data_valid outside WAIT_RD: ignored, no rsp_valid.
  - Reset mid-operation: FIFO is emptied, FSM goes to IDLE, and any pending read is discarded with no response.

## Timing

- Reset values:
  - req_ready=0, then 1 from the first cycle after reset is released.
  - rsp_valid=0, rsp_rdata=0.
  - mc_enable=0, mc_valid=0, mc_cmd=0, mc_addr=0, mc_wr_data=0.
- mc_enable is registered: 0 during reset, 1 from the first cycle after release.
- Minimum latency, push to mc_valid: 2 cycles (push at cycle N, IDLE decision at N+1, ISSUE at N+2), given mc_data_rdy=1.
- Write turnaround: minimum 3 cycles between consecutive mc_valid pulses (ISSUE, HOLD, IDLE).
- Read return: rsp_valid asserts exactly 1 cycle after mc_rd_data_valid is sampled in WAIT_RD.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration

- DDR3_REQ_QUEUE_STATS_EN
  - Defined: adds outputs o_wr_issued, o_rd_issued and o_stall_cycles, each 16-bit and saturating at 0xFFFF, all reset to 0.
    - o_wr_issued counts write ISSUE cycles.
    - o_rd_issued counts read ISSUE cycles.
    - o_stall_cycles counts cycles in IDLE with a non-empty FIFO and mc_data_rdy=0.
  - Undefined: these ports and their counters do not exist; all other behaviour is identical.

## Test plan

- Reset then idle: hold i_cpu_reset for 3 cycles, then release. Required: all outputs are 0 during reset, req_ready=1 and mc_enable=1 one cycle after release, and mc_valid stays 0.
- Single write: push cmd=1, addr=0x0000100, wdata=0xDEADBEEF_CAFEF00D with mc_data_rdy=1. Required: one mc_valid pulse exactly 2 cycles later, carrying the same cmd/addr/data.
- Single read: push cmd=0, addr=0x0000100. Return mc_rd_data=0x0123456789ABCDEF with mc_rd_data_valid 10 cycles after issue. Required: rsp_valid pulse 1 cycle later with that data.
- Fill: push 5 writes back-to-back with DEPTH=4 and mc_data_rdy=0. Required: req_ready falls after the 4th push and the 5th is held off. When mc_data_rdy rises, the 4 entries issue in order, at least 3 cycles apart.
- Mixed ordering: write A, read A, write B, read B, with a controller model that echoes stored data. Required: responses return in order with A's and B's data, and never more than one transaction is outstanding.
- Reset mid-read: assert reset while in WAIT_RD, then pulse mc_rd_data_valid after release. Required: no rsp_valid and the FIFO is empty.
